// File: rtl/xc_sha3_lane_seq_if.sv
// rtl/xc_sha3_lane_seq_if.sv - control, datapath-select and lane-index stream bundle for xc_sha3_lane_seq
// master = sequencer side, slave = micro-sequencer / datapath / LSU side
interface xc_sha3_lane_seq_if;
    logic        start;
    logic        abort;
    logic [2:0]  mode;
    logic [1:0]  shamt_cfg;
    logic        busy;
    logic        done;
    logic        err;
    logic        chk_fail;
    logic [31:0] dp_rs1;
    logic [31:0] dp_rs2;
    logic [1:0]  dp_shamt;
    logic        dp_f_xy;
    logic        dp_f_x1;
    logic        dp_f_x2;
    logic        dp_f_x4;
    logic        dp_f_yx;
    logic [31:0] dp_result;
    logic        idx_valid;
    logic        idx_ready;
    logic [31:0] idx_data;
    logic [2:0]  idx_x;
    logic [2:0]  idx_y;
    logic        idx_last;

    modport master (
        input  start, abort, mode, shamt_cfg, dp_result, idx_ready,
        output busy, done, err, chk_fail,
        output dp_rs1, dp_rs2, dp_shamt,
        output dp_f_xy, dp_f_x1, dp_f_x2, dp_f_x4, dp_f_yx,
        output idx_valid, idx_data, idx_x, idx_y, idx_last
    );

    modport slave (
        output start, abort, mode, shamt_cfg, dp_result, idx_ready,
        input  busy, done, err, chk_fail,
        input  dp_rs1, dp_rs2, dp_shamt,
        input  dp_f_xy, dp_f_x1, dp_f_x2, dp_f_x4, dp_f_yx,
        input  idx_valid, idx_data, idx_x, idx_y, idx_last
    );
endinterface

// File: rtl/xc_sha3_lane_seq.sv
// rtl/xc_sha3_lane_seq.sv - walks the 25 Keccak lanes through the xc_sha3 index datapath and streams the results
// Optional reference checker on the datapath result: XC_SHA3_LANE_SEQ_CHECK_EN
module xc_sha3_lane_seq (
    input  logic                   i_clock,
    input  logic                   i_resetn,
    xc_sha3_lane_seq_if.master     bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_x;
    logic [2:0] r_y;
    logic [2:0] w_x_nxt;
    logic [2:0] w_y_nxt;
    logic [2:0] r_mode;
    logic [2:0] w_mode_nxt;
    logic [1:0] r_shamt;
    logic [1:0] w_shamt_nxt;
    logic       r_err;
    logic       w_err_nxt;

    logic       w_run;
    logic       w_last;
    logic       w_fire;
    logic       w_mode_ok;

    assign w_run     = (r_state == ST_RUN);
    assign w_last    = w_run && (r_x == 3'd4) && (r_y == 3'd4);
    assign w_fire    = w_run && bus.idx_ready;
    assign w_mode_ok = (bus.mode <= 3'd4);

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= ST_IDLE;
            r_x     <= 3'd0;
            r_y     <= 3'd0;
            r_mode  <= 3'd0;
            r_shamt <= 2'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_mode  <= w_mode_nxt;
            r_shamt <= w_shamt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // abort is checked before the handshake so a same-cycle accept is discarded
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_mode_nxt  = r_mode;
        w_shamt_nxt = r_shamt;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (w_mode_ok) begin
                        w_state_nxt = ST_RUN;
                        w_mode_nxt  = bus.mode;
                        w_shamt_nxt = bus.shamt_cfg;
                        w_x_nxt     = 3'd0;
                        w_y_nxt     = 3'd0;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                    w_x_nxt     = 3'd0;
                    w_y_nxt     = 3'd0;
                end else if (w_fire) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                        w_x_nxt     = 3'd0;
                        w_y_nxt     = 3'd0;
                    end else if (r_x == 3'd4) begin
                        w_x_nxt     = 3'd0;
                        w_y_nxt     = r_y + 3'd1;
                    end else begin
                        w_x_nxt     = r_x + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_x_nxt     = 3'd0;
                w_y_nxt     = 3'd0;
            end
        endcase
    end

    assign bus.busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.err       = r_err;

    assign bus.dp_rs1    = {29'd0, r_x};
    assign bus.dp_rs2    = {29'd0, r_y};
    assign bus.dp_shamt  = r_shamt;
    assign bus.dp_f_xy   = w_run && (r_mode == 3'd0);
    assign bus.dp_f_x1   = w_run && (r_mode == 3'd1);
    assign bus.dp_f_x2   = w_run && (r_mode == 3'd2);
    assign bus.dp_f_x4   = w_run && (r_mode == 3'd3);
    assign bus.dp_f_yx   = w_run && (r_mode == 3'd4);

    assign bus.idx_valid = w_run;
    assign bus.idx_data  = w_run ? bus.dp_result : 32'd0;
    assign bus.idx_x     = r_x;
    assign bus.idx_y     = r_y;
    assign bus.idx_last  = w_last;

`ifdef XC_SHA3_LANE_SEQ_CHECK_EN
    function automatic logic [2:0] mod5(input logic [4:0] v);
        logic [4:0] t;
        t = v;
        if (t >= 5'd20)      t = t - 5'd20;
        else if (t >= 5'd15) t = t - 5'd15;
        else if (t >= 5'd10) t = t - 5'd10;
        else if (t >= 5'd5)  t = t - 5'd5;
        return t[2:0];
    endfunction

    logic [2:0]  w_ref_x;
    logic [2:0]  w_ref_y;
    logic [4:0]  w_ref_lane;
    logic [31:0] w_ref_idx;
    logic        r_chk_fail;

    // every mode reduces to lane = rx + 5*ry with a per-mode (rx, ry)
    always_comb begin
        w_ref_x = r_x;
        w_ref_y = r_y;
        case (r_mode)
            3'd1: w_ref_x = mod5({2'b00, r_x} + 5'd1);
            3'd2: w_ref_x = mod5({2'b00, r_x} + 5'd2);
            3'd3: w_ref_x = mod5({2'b00, r_x} + 5'd4);
            3'd4: begin
                w_ref_x = r_y;
                w_ref_y = mod5({1'b0, r_x, 1'b0} + 5'd3 * {2'b00, r_y});
            end
            default: ;
        endcase
        w_ref_lane = {2'b00, w_ref_x} + 5'd5 * {2'b00, w_ref_y};
        w_ref_idx  = {27'd0, w_ref_lane} << r_shamt;
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_chk_fail <= 1'b0;
        end else if (w_run && (bus.dp_result != w_ref_idx)) begin
            r_chk_fail <= 1'b1;
        end
    end

    assign bus.chk_fail = r_chk_fail;
`else
    assign bus.chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_xc_sha3_lane_seq.sv
// tb/tb_xc_sha3_lane_seq.sv - directed scoreboard bench for xc_sha3_lane_seq
module tb_xc_sha3_lane_seq;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  x;
        logic [2:0]  y;
        logic        last;
    } beat_t;

    logic  clock;
    logic  resetn;
    int    total = 0;
    int    bad   = 0;
    beat_t sb[$];

    xc_sha3_lane_seq_if ifc ();

    xc_sha3_lane_seq dut (
        .i_clock  (clock),
        .i_resetn (resetn),
        .bus      (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // behavioural xc_sha3 index datapath
    always_comb begin
        int x, y, lane;
        x    = int'(ifc.dp_rs1[2:0]);
        y    = int'(ifc.dp_rs2[2:0]);
        lane = 0;
        if (ifc.dp_f_xy)      lane = x + 5 * y;
        else if (ifc.dp_f_x1) lane = (x + 1) % 5 + 5 * y;
        else if (ifc.dp_f_x2) lane = (x + 2) % 5 + 5 * y;
        else if (ifc.dp_f_x4) lane = (x + 4) % 5 + 5 * y;
        else if (ifc.dp_f_yx) lane = y + 5 * ((2 * x + 3 * y) % 5);
        ifc.dp_result = 32'(lane) << ifc.dp_shamt;
    end

    function automatic beat_t exp_beat(input int m, input int sh, input int i);
        beat_t b;
        int x, y, lane;
        x = i % 5;
        y = i / 5;
        case (m)
            0:       lane = x + 5 * y;
            1:       lane = (x + 1) % 5 + 5 * y;
            2:       lane = (x + 2) % 5 + 5 * y;
            3:       lane = (x + 4) % 5 + 5 * y;
            default: lane = y + 5 * ((2 * x + 3 * y) % 5);
        endcase
        b.d    = 32'(lane) << sh;
        b.x    = 3'(x);
        b.y    = 3'(y);
        b.last = (i == 24);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  {31'd0, ifc.busy}, 32'd0);
        chk({tag, "_done"},  {31'd0, ifc.done}, 32'd0);
        chk({tag, "_err"},   {31'd0, ifc.err}, 32'd0);
        chk({tag, "_valid"}, {31'd0, ifc.idx_valid}, 32'd0);
        chk({tag, "_data"},  ifc.idx_data, 32'd0);
        chk({tag, "_xy"},    {26'd0, ifc.idx_x, ifc.idx_y}, 32'd0);
        chk({tag, "_last"},  {31'd0, ifc.idx_last}, 32'd0);
        chk({tag, "_fsel"},  {27'd0, ifc.dp_f_xy, ifc.dp_f_x1, ifc.dp_f_x2, ifc.dp_f_x4, ifc.dp_f_yx}, 32'd0);
        chk({tag, "_rs"},    ifc.dp_rs1 | ifc.dp_rs2, 32'd0);
        chk({tag, "_shamt"}, {30'd0, ifc.dp_shamt}, 32'd0);
        chk({tag, "_chkf"},  {31'd0, ifc.chk_fail}, 32'd0);
    endtask

    // one sweep; stall_at/abort_at are 0-based beat indices, -1 disables
    task automatic sweep(input string tag, input int m, input int sh,
                         input int stall_at, input int stall_len, input int abort_at);
        int beats;
        int stalled;
        int cyc;
        beats   = 0;
        stalled = 0;
        sb.delete();
        for (int i = 0; i < 25; i++) sb.push_back(exp_beat(m, sh, i));
        @(negedge clock);
        ifc.start     = 1'b1;
        ifc.mode      = 3'(m);
        ifc.shamt_cfg = 2'(sh);
        @(negedge clock);
        ifc.mode      = (m == 0) ? 3'd4 : 3'd0;
        ifc.shamt_cfg = ~2'(sh);
        for (cyc = 1; cyc <= 60; cyc++) begin
            if (cyc > 1) @(negedge clock);
            ifc.start     = (cyc == 3);
            ifc.idx_ready = !(beats == stall_at && stalled < stall_len);
            ifc.abort     = (beats == abort_at);
            #1;
            if (ifc.idx_valid !== 1'b1) break;
            chk({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() == 0) break;
            chk({tag, "_data"}, ifc.idx_data, sb[0].d);
            chk({tag, "_xy"},   {26'd0, ifc.idx_x, ifc.idx_y}, {26'd0, sb[0].x, sb[0].y});
            chk({tag, "_last"}, {31'd0, ifc.idx_last}, {31'd0, sb[0].last});
            if (ifc.abort) begin
                @(negedge clock);
                ifc.abort = 1'b0;
                ifc.start = 1'b0;
                #1;
                chk({tag, "_abort_valid"}, {31'd0, ifc.idx_valid}, 32'd0);
                chk({tag, "_abort_busy"},  {31'd0, ifc.busy}, 32'd0);
                chk({tag, "_abort_done"},  {31'd0, ifc.done}, 32'd0);
                chk({tag, "_abort_xy"},    {26'd0, ifc.idx_x, ifc.idx_y}, 32'd0);
                @(negedge clock);
                #1;
                chk({tag, "_abort_nodone"}, {31'd0, ifc.done | ifc.idx_valid}, 32'd0);
                return;
            end
            if (ifc.idx_ready) begin
                void'(sb.pop_front());
                beats++;
            end else begin
                stalled++;
            end
        end
        ifc.start = 1'b0;
        chk({tag, "_beats"},      32'(beats), 32'd25);
        chk({tag, "_done_pulse"}, {31'd0, ifc.done}, 32'd1);
        chk({tag, "_done_busy"},  {31'd0, ifc.busy}, 32'd1);
        chk({tag, "_done_cycle"}, 32'(cyc), 32'(26 + stall_len));
        @(negedge clock);
        #1;
        chk({tag, "_idle_busy"}, {31'd0, ifc.busy}, 32'd0);
        chk({tag, "_idle_done"}, {31'd0, ifc.done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn        = 1'b0;
        ifc.start     = 1'b0;
        ifc.abort     = 1'b0;
        ifc.mode      = 3'd0;
        ifc.shamt_cfg = 2'd0;
        ifc.idx_ready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk_all_zero("reset");
        resetn = 1'b1;

        sweep("t1", 0, 0, -1, 0, -1);
        sweep("t2", 4, 2, -1, 0, -1);
        sweep("t3", 3, 0, 5, 3, -1);
        sweep("t4a", 1, 0, -1, 0, 9);
        sweep("t4b", 1, 0, -1, 0, -1);
        sweep("t2b", 2, 1, 17, 2, -1);
        chk("chk_fail_clean", {31'd0, ifc.chk_fail}, 32'd0);

        // invalid mode
        @(negedge clock);
        ifc.start = 1'b1;
        ifc.mode  = 3'd6;
        @(negedge clock);
        ifc.start = 1'b0;
        #1;
        chk("t5_err",   {31'd0, ifc.err}, 32'd1);
        chk("t5_busy",  {31'd0, ifc.busy}, 32'd0);
        chk("t5_valid", {31'd0, ifc.idx_valid}, 32'd0);
        chk("t5_fsel",  {27'd0, ifc.dp_f_xy, ifc.dp_f_x1, ifc.dp_f_x2, ifc.dp_f_x4, ifc.dp_f_yx}, 32'd0);
        @(negedge clock);
        #1;
        chk("t5_err_once", {31'd0, ifc.err}, 32'd0);
        chk("t5_no_beat",  {31'd0, ifc.idx_valid | ifc.busy}, 32'd0);

        // asynchronous reset in the middle of a sweep
        @(negedge clock);
        ifc.start     = 1'b1;
        ifc.mode      = 3'd0;
        ifc.shamt_cfg = 2'd3;
        @(negedge clock);
        ifc.start = 1'b0;
        repeat (12) @(negedge clock);
        #1;
        chk("t6_pre_xy", {26'd0, ifc.idx_x, ifc.idx_y}, {26'd0, 3'd2, 3'd2});
        #2;
        resetn = 1'b0;
        #1;
        chk_all_zero("t6");
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        #1;
        chk("t6_stays_idle", {31'd0, ifc.busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
